beat_song_counter: RTL
======================

Name: beat_song_counter

Overview:
- Parametrised successor to the single-song finish counter.
- Counts beat strobes derived from the beat clock through a configurable lead-in and a run-time song length.
- Supports start, pause/resume and abort, and reports progress, beats left and a near-end warning.
- Signals song end with a held finish level plus a one-cycle finish pulse for the game FSM and score logic.

Parameters:
- BEAT_W, 8, width of song length, beat count and beats-left values.
- LEAD_IN, 4, beats counted before play counting starts. 0 means no lead-in.
- WARN_BEATS, 8, near_end asserts when beats_left is between 1 and WARN_BEATS inclusive.

Ports:
- clk  in  1  system clock (12 MHz).
- n_rst  in  1  asynchronous active-low reset.
- beat_clk  in  1  beat clock level, already synchronous to clk; each rising edge is one beat.
- start  in  1  one-cycle request to begin a song.
- song_len  in  BEAT_W  number of play beats; sampled only on an accepted start.
- pause  in  1  level; while 1, beats are ignored.
- abort  in  1  one-cycle request to return to IDLE.
- beat_count  out  BEAT_W  play beats elapsed.
- beats_left  out  BEAT_W  latched length minus beat_count.
- playing  out  1  high in LEADIN or PLAY, low in PAUSED.
- near_end  out  1  end-of-song warning.
- finish  out  1  song complete (level).
- finish_pulse  out  1  single-cycle completion strobe.

Behaviour:
- Reset (async, n_rst=0): state IDLE; beat_q, beat_count, beats_left, latched length and lead-in count all 0; every output 0.
- Beat detect: beat_q is a register of beat_clk. tick = beat_clk & ~beat_q. A beat_clk already high when reset releases yields one tick on the first clock.
- State machine (IDLE, LEADIN, PLAY, PAUSED, FINISHED):
  - IDLE or FINISHED, start=1: latch song_len, clear beat_count, clear finish. Next state is LEADIN if LEAD_IN>0, else PLAY.
  - start=1 with song_len=0: go directly to FINISHED. finish_pulse fires on the next cycle.
  - LEADIN: each tick increments the lead-in counter. The LEAD_IN-th tick moves to PLAY; beat_count is unchanged.
  - PLAY: each tick increments beat_count and decrements beats_left on the same clk edge.
  - PLAY, tick that makes beat_count equal the latched length: go to FINISHED. On that same edge finish=1 and finish_pulse=1. finish_pulse is 1 for exactly one cycle; finish holds until the next start or abort.
  - LEADIN or PLAY with pause=1: go to PAUSED and remember the origin state. Ticks in that cycle and while PAUSED are dropped.
  - PAUSED with pause=0: return to the origin state with counts intact.
  - abort=1 in any state: IDLE; beat_count, beats_left and finish cleared. No finish_pulse.
- Priority per cycle: abort > start > pause > tick.
- start is ignored in LEADIN, PLAY and PAUSED.
- In FINISHED, start restarts directly with no intermediate IDLE cycle.
- Outputs:
  - beats_left = length - beat_count, registered. Width BEAT_W, never wraps; beat_count never exceeds the length.
  - near_end = (state==PLAY) & (beats_left != 0) & (beats_left <= WARN_BEATS), registered from next-state values so it aligns with beat_count.
  - Ticks in IDLE and FINISHED are ignored.

Test Plan:
- Reset, start with song_len=20 and default params, then 4 ticks. playing=1 and beat_count=0 throughout lead-in. After 20 more ticks: beat_count=20, beats_left=0, finish=1, finish_pulse high for exactly 1 cycle, playing=0.
- Same run, watch near_end: it rises on the edge where beats_left becomes 8 (12th play tick), stays high through beats_left=1, and is low once finish=1.
- Pause at beat_count=5, toggle beat_clk 6 times, release pause, then 15 more ticks. beat_count is held at 5 while paused; finish occurs only after the 15th post-resume tick.
- Abort at beat_count=10: next cycle IDLE, beat_count=0, finish=0, no finish_pulse. Ticks then ignored. A new start with song_len=3 and LEAD_IN=4 finishes after 7 ticks.
- start with song_len=0 → finish_pulse exactly once, finish=1, beat_count=0. From FINISHED, start with song_len=2 clears finish, and a second finish_pulse follows 6 ticks later.
- Simultaneous events:
  - abort and start in the same cycle → IDLE.
  - pause asserted on a tick cycle → the tick is not counted.
  - Async reset asserted mid-PLAY between clk edges → all outputs 0 immediately.

Source files
------------

// File: rtl/beat_song_counter.sv
// Beat-driven song progress counter: optional lead-in, pause/resume, abort,
// beats-left and near-end reporting, and a held finish level plus a finish strobe.
module beat_song_counter #(
  parameter int BEAT_W     = 8,
  parameter int LEAD_IN    = 4,
  parameter int WARN_BEATS = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              beat_clk,
  input  logic              start,
  input  logic [BEAT_W-1:0] song_len,
  input  logic              pause,
  input  logic              abort,
  output logic [BEAT_W-1:0] beat_count,
  output logic [BEAT_W-1:0] beats_left,
  output logic              playing,
  output logic              near_end,
  output logic              finish,
  output logic              finish_pulse
);

  // state      | meaning
  // S_IDLE     | no song loaded, waiting for start
  // S_LEADIN   | counting lead-in beats, play count frozen
  // S_PLAY     | counting play beats toward the latched length
  // S_PAUSED   | beats dropped, origin_q holds the state to resume
  // S_FINISHED | song complete, finish held until start or abort
  typedef enum logic [2:0] {
    S_IDLE, S_LEADIN, S_PLAY, S_PAUSED, S_FINISHED
  } state_t;

  localparam int LW = (LEAD_IN > 0) ? $clog2(LEAD_IN + 1) : 1;
  localparam logic [LW-1:0]     LEAD_LAST = LW'(LEAD_IN);
  localparam logic [BEAT_W-1:0] WARN_LIM  = BEAT_W'(WARN_BEATS);

  state_t            state_q, state_d, origin_q, origin_d;
  logic              beat_q;
  logic [BEAT_W-1:0] len_q, len_d;
  logic [LW-1:0]     lead_q, lead_d;
  logic [BEAT_W-1:0] count_q, count_d;
  logic [BEAT_W-1:0] left_q, left_d;
  logic              finish_q, finish_d;
  logic              pulse_q, pulse_d;
  logic              near_q, near_d;
  logic              tick;

  assign tick = beat_clk & ~beat_q;

  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    len_d    = len_q;
    lead_d   = lead_q;
    count_d  = count_q;
    left_d   = left_q;
    finish_d = finish_q;
    pulse_d  = 1'b0;

    if (abort) begin
      state_d  = S_IDLE;
      lead_d   = '0;
      count_d  = '0;
      left_d   = '0;
      finish_d = 1'b0;
    end else if (start && (state_q == S_IDLE || state_q == S_FINISHED)) begin
      len_d    = song_len;
      lead_d   = '0;
      count_d  = '0;
      left_d   = song_len;
      finish_d = 1'b0;
      if (song_len == '0) begin
        state_d  = S_FINISHED;
        finish_d = 1'b1;
        pulse_d  = 1'b1;
      end else begin
        state_d = (LEAD_IN > 0) ? S_LEADIN : S_PLAY;
      end
    end else if (pause && (state_q == S_LEADIN || state_q == S_PLAY)) begin
      origin_d = state_q;
      state_d  = S_PAUSED;
    end else if (state_q == S_PAUSED) begin
      // a beat arriving on the resume cycle is still dropped
      if (!pause) state_d = origin_q;
    end else if (tick) begin
      case (state_q)
        S_LEADIN: begin
          lead_d = lead_q + 1'b1;
          if (lead_d == LEAD_LAST) begin
            lead_d  = '0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          count_d = count_q + 1'b1;
          left_d  = left_q - 1'b1;
          if (count_d == len_q) begin
            state_d  = S_FINISHED;
            finish_d = 1'b1;
            pulse_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    near_d = (state_d == S_PLAY) && (left_d != '0) && (left_d <= WARN_LIM);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      origin_q <= S_IDLE;
      beat_q   <= 1'b0;
      len_q    <= '0;
      lead_q   <= '0;
      count_q  <= '0;
      left_q   <= '0;
      finish_q <= 1'b0;
      pulse_q  <= 1'b0;
      near_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      origin_q <= origin_d;
      beat_q   <= beat_clk;
      len_q    <= len_d;
      lead_q   <= lead_d;
      count_q  <= count_d;
      left_q   <= left_d;
      finish_q <= finish_d;
      pulse_q  <= pulse_d;
      near_q   <= near_d;
    end
  end

  assign beat_count   = count_q;
  assign beats_left   = left_q;
  assign playing      = (state_q == S_LEADIN) || (state_q == S_PLAY);
  assign near_end     = near_q;
  assign finish       = finish_q;
  assign finish_pulse = pulse_q;

endmodule
